// File: rtl/alu_sequencer.sv
// Sequences one ARM data-processing op at a time through a shared external ALU:
// it latches the request, evaluates the condition, updates NZCV and hands the result to writeback.
// Optional macro ALU_SEQ_COND_EN enables ARM conditional execution; when it is undefined, every op runs as AL.
module alu_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [3:0]        req_cond,
  input  logic              req_s,
  input  logic [3:0]        req_rd,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  // shared ALU
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [3:0]        alu_control,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  // writeback
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  // flags
  input  logic              flag_wr_en,
  input  logic [3:0]        flag_wr_data,
  output logic [3:0]        cpsr_nzcv
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        op_q;
  logic              s_q;
  logic [3:0]        rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              accept;
  logic              cond_ok;
  logic              is_compare;
  logic              exec_pass;

  assign accept     = req_valid && req_ready;
  assign is_compare = (op_q[3:2] == 2'b10);  // TST/TEQ/CMP/CMN: flags only
  assign exec_pass  = (state == EXEC) && cond_ok;

  assign alu_operand_a = a_q;
  assign alu_operand_b = b_q;
  assign alu_control   = op_q;
  assign alu_carry_in  = cpsr_nzcv[1];

`ifdef ALU_SEQ_COND_EN
  logic [3:0] cond_q;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = cpsr_nzcv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cond_q <= '0;
    else if (accept) cond_q <= req_cond;
  end

  // Flags seen here are the ones before this op's own update.
  always_comb begin
    cond_ok = 1'b0;
    unique case (cond_q)
      4'h0: cond_ok = flag_z;
      4'h1: cond_ok = !flag_z;
      4'h2: cond_ok = flag_c;
      4'h3: cond_ok = !flag_c;
      4'h4: cond_ok = flag_n;
      4'h5: cond_ok = !flag_n;
      4'h6: cond_ok = flag_v;
      4'h7: cond_ok = !flag_v;
      4'h8: cond_ok = flag_c && !flag_z;
      4'h9: cond_ok = !flag_c || flag_z;
      4'hA: cond_ok = (flag_n == flag_v);
      4'hB: cond_ok = (flag_n != flag_v);
      4'hC: cond_ok = !flag_z && (flag_n == flag_v);
      4'hD: cond_ok = flag_z || (flag_n != flag_v);
      4'hE: cond_ok = 1'b1;
      4'hF: cond_ok = 1'b0;
      default: cond_ok = 1'b0;
    endcase
  end
`else
  logic unused_cond;

  assign unused_cond = ^req_cond;
  assign cond_ok     = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first keeps this block combinational (no latch inferred).
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = (cond_ok && !is_compare) ? WB : IDLE;
      WB:   if (wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == IDLE);
  end

  // Request latch; holds across EXEC/WB so the ALU inputs stay steady.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is reset, so no stale operand survives a reset.
    if (!rst_n) begin
      op_q <= '0;
      s_q  <= 1'b0;
      rd_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= req_op;
      s_q  <= req_s;
      rd_q <= req_rd;
      a_q  <= req_a;
      b_q  <= req_b;
    end
  end

  // Flags: an external MSR write overrides a same-cycle EXEC update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cpsr_nzcv <= 4'b0000;
    else if (flag_wr_en)
      cpsr_nzcv <= flag_wr_data;
    else if (exec_pass && (s_q || is_compare))
      cpsr_nzcv <= {alu_negative, alu_zero, alu_carry, alu_overflow};
  end

  // Writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
    end else if (exec_pass && !is_compare) begin
      wb_valid <= 1'b1;
      wb_data  <= alu_result;
      wb_rd    <= rd_q;
    end else if (state == WB && wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ARM ALU, directed vector table,
// hand-written stall/override/reset sequences and randomized ops against a transaction-level model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_s;
  logic [3:0]  req_op, req_cond, req_rd;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_carry_in, alu_zero, alu_carry, alu_overflow, alu_negative;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flag_wr_en;
  logic [3:0]  flag_wr_data, cpsr_nzcv;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] model_nzcv;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cond(req_cond),
    .req_s(req_s), .req_rd(req_rd), .req_a(req_a), .req_b(req_b),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_control(alu_control),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_negative(alu_negative),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_wr_en(flag_wr_en), .flag_wr_data(flag_wr_data), .cpsr_nzcv(cpsr_nzcv)
  );

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  nzcv;
  } alu_out_t;

  // Behavioural ARM data-processing ALU (no shifter; logical ops pass carry-in to C, V=0).
  function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [31:0] a, b,
                                      input logic cin);
    logic [32:0] sum;
    logic [31:0] x, y, r;
    logic        arith, c, v;
    arith = 1'b1;
    x = a; y = b; sum = '0; r = '0;
    case (op)
      4'h2, 4'hA: begin x = a; y = ~b; sum = {1'b0, x} + {1'b0, y} + 33'd1; end
      4'h3:       begin x = b; y = ~a; sum = {1'b0, x} + {1'b0, y} + 33'd1; end
      4'h4, 4'hB: begin x = a; y = b;  sum = {1'b0, x} + {1'b0, y}; end
      4'h5:       begin x = a; y = b;  sum = {1'b0, x} + {1'b0, y} + {32'd0, cin}; end
      4'h6:       begin x = a; y = ~b; sum = {1'b0, x} + {1'b0, y} + {32'd0, cin}; end
      4'h7:       begin x = b; y = ~a; sum = {1'b0, x} + {1'b0, y} + {32'd0, cin}; end
      default:    arith = 1'b0;
    endcase
    if (arith) begin
      r = sum[31:0];
      c = sum[32];
      v = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      case (op)
        4'h0, 4'h8: r = a & b;
        4'h1, 4'h9: r = a ^ b;
        4'hC:       r = a | b;
        4'hD:       r = b;
        4'hE:       r = a & ~b;
        default:    r = ~b;
      endcase
      c = cin;
      v = 1'b0;
    end
    return '{r: r, nzcv: {r[31], (r == 32'd0), c, v}};
  endfunction

  alu_out_t alu_o;
  always_comb begin
    alu_o        = alu_fn(alu_control, alu_operand_a, alu_operand_b, alu_carry_in);
    alu_result   = alu_o.r;
    alu_negative = alu_o.nzcv[3];
    alu_zero     = alu_o.nzcv[2];
    alu_carry    = alu_o.nzcv[1];
    alu_overflow = alu_o.nzcv[0];
  end

  // Condition rule from the ARM table; every op is AL when conditional execution is compiled out.
  function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] f);
`ifdef ALU_SEQ_COND_EN
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;             4'h1: return !z;
      4'h2: return c;             4'h3: return !c;
      4'h4: return n;             4'h5: return !n;
      4'h6: return v;             4'h7: return !v;
      4'h8: return c && !z;       4'h9: return !c || z;
      4'hA: return n == v;        4'hB: return n != v;
      4'hC: return !z && (n == v); 4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (cond == cond) && (f == f);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_wr_en = 1'b1; flag_wr_data = f;
    tick();
    flag_wr_en = 1'b0;
    model_nzcv = f;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    ok = req_ready;
    if (!ok) check("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // One full transaction with explicit expectations; stall = cycles wb_ready stays low in WB.
  task automatic run_op(input string tag, input logic [3:0] op, cond, input logic s,
                        input logic [3:0] rd, input logic [31:0] a, b, input int stall,
                        input logic exp_wb, input logic [31:0] exp_data,
                        input logic [3:0] exp_nzcv);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    req_op = op; req_cond = cond; req_s = s; req_rd = rd; req_a = a; req_b = b;
    req_valid = 1'b1;
    wb_ready  = (stall == 0);
    tick();                       // E0: accepted, now EXEC
    req_valid = 1'b0;
    tick();                       // E1: flags/writeback registered
    check({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, exp_wb});
    check({tag, ".nzcv"}, {28'd0, cpsr_nzcv}, {28'd0, exp_nzcv});
    if (exp_wb) begin
      check({tag, ".wb_data"}, wb_data, exp_data);
      check({tag, ".wb_rd"}, {28'd0, wb_rd}, {28'd0, rd});
      for (int i = 0; i < stall; i++) begin
        tick();
        if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_rd !== rd || req_ready !== 1'b0)
          check({tag, ".wb_hold"}, {wb_valid, req_ready, wb_rd, wb_data[25:0]},
                {1'b1, 1'b0, rd, exp_data[25:0]});
      end
      wb_ready = 1'b1;
      tick();                     // handshake edge
      check({tag, ".wb_done"}, {30'd0, wb_valid, req_ready}, 32'd1);
    end else begin
      check({tag, ".ready_back"}, {31'd0, req_ready}, 32'd1);
    end
    model_nzcv = exp_nzcv;
  endtask

  // Expected outcome from the model, then run the transaction.
  task automatic model_op(input string tag, input logic [3:0] op, cond, input logic s,
                          input logic [3:0] rd, input logic [31:0] a, b, input int stall);
    alu_out_t m;
    bit pass, writes;
    logic [3:0] nz;
    pass   = cond_holds(cond, model_nzcv);
    m      = alu_fn(op, a, b, model_nzcv[1]);
    writes = pass && !(op >= 4'h8 && op <= 4'hB);
    nz     = (pass && (s || (op >= 4'h8 && op <= 4'hB))) ? m.nzcv : model_nzcv;
    run_op(tag, op, cond, s, rd, a, b, stall, writes, m.r, nz);
  endtask

  typedef struct {
    logic [3:0]  op, cond;
    logic        s;
    logic [3:0]  rd;
    logic [31:0] a, b;
    logic        exp_wb;
    logic [31:0] exp_data;
    logic [3:0]  exp_nzcv;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit ok;
    logic [31:0] held_a;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_cond = 4'hE; req_s = 1'b0;
    req_rd = '0; req_a = '0; req_b = '0; wb_ready = 1'b1; flag_wr_en = 1'b0;
    flag_wr_data = '0; model_nzcv = 4'b0000;

    vecs[0] = '{4'h4, 4'hE, 1'b1, 4'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'hFFFFFFFF, 4'b1000};
    vecs[1] = '{4'hA, 4'hE, 1'b0, 4'd0, 32'd5,        32'd5,        1'b0, 32'd0,        4'b0110};
    vecs[2] = '{4'h2, 4'hE, 1'b0, 4'd1, 32'd10,       32'd3,        1'b1, 32'd7,        4'b0110};
    vecs[3] = '{4'h5, 4'hE, 1'b1, 4'd2, 32'd1,        32'd1,        1'b1, 32'd3,        4'b0000};
    vecs[4] = '{4'h4, 4'hE, 1'b1, 4'd4, 32'h7FFFFFFF, 32'd1,        1'b1, 32'h80000000, 4'b1001};
    vecs[5] = '{4'hD, 4'hE, 1'b1, 4'd5, 32'd0,        32'd0,        1'b1, 32'd0,        4'b0100};
    vecs[6] = '{4'hF, 4'hE, 1'b0, 4'd6, 32'd0,        32'd0,        1'b1, 32'hFFFFFFFF, 4'b0100};
    vecs[7] = '{4'h8, 4'hE, 1'b0, 4'd0, 32'hF0,       32'h0F,       1'b0, 32'd0,        4'b0100};
    vecs[8] = '{4'hB, 4'hE, 1'b0, 4'd0, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        4'b0110};
    vecs[9] = '{4'h2, 4'hE, 1'b1, 4'd7, 32'd0,        32'd1,        1'b1, 32'hFFFFFFFF, 4'b1000};

    #2;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst.nzcv", {28'd0, cpsr_nzcv}, 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.alu_ctl", {alu_control, alu_operand_a[27:0]}, 32'd0);
    #20 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].cond, vecs[i].s, vecs[i].rd,
             vecs[i].a, vecs[i].b, 0, vecs[i].exp_wb, vecs[i].exp_data, vecs[i].exp_nzcv);

    // Condition EQ with Z clear: skipped when conditional, executes when compiled out.
    set_flags(4'b0000);
    model_op("sub_eq", 4'h2, 4'h0, 1'b1, 4'd9, 32'd20, 32'd8, 0);

    // Writeback stalled five cycles while a new request is offered and must be ignored.
    wait_ready(ok);
    req_op = 4'hC; req_cond = 4'hE; req_s = 1'b0; req_rd = 4'd11;
    req_a = 32'h1234_0000; req_b = 32'h0000_5678; req_valid = 1'b1; wb_ready = 1'b0;
    tick(); req_valid = 1'b0; tick();
    check("stall.wb_data", wb_data, 32'h12345678);
    held_a = 32'h1234_0000;
    req_valid = 1'b1; req_a = 32'hDEADBEEF; req_op = 4'h1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wb_valid !== 1'b1 || wb_data !== 32'h12345678 || wb_rd !== 4'd11 || req_ready !== 1'b0)
        check("stall.hold", {wb_valid, req_ready, wb_rd, wb_data[25:0]},
              {1'b1, 1'b0, 4'd11, 26'h2345678});
    end
    check("stall.cycles", {31'd0, wb_valid}, 32'd1);
    req_valid = 1'b0; wb_ready = 1'b1;
    tick();
    check("stall.release", {30'd0, wb_valid, req_ready}, 32'd1);
    check("stall.ignored", alu_operand_a, held_a);

    // MSR write coinciding with an EXEC flag update (ADDS 0+0 -> 0100) wins.
    set_flags(4'b0000);
    req_op = 4'h4; req_cond = 4'hE; req_s = 1'b1; req_rd = 4'd1; req_a = 0; req_b = 0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0; flag_wr_en = 1'b1; flag_wr_data = 4'b0001;
    tick();
    flag_wr_en = 1'b0;
    check("msr_wins", {28'd0, cpsr_nzcv}, 32'h1);
    tick();
    model_nzcv = 4'b0001;

    // Reset pulse during WB drops the in-flight op.
    set_flags(4'b1010);
    req_op = 4'hD; req_cond = 4'hE; req_s = 1'b1; req_rd = 4'd4; req_b = 32'h55;
    req_valid = 1'b1; wb_ready = 1'b0;
    tick(); req_valid = 1'b0; tick();
    check("rstwb.pre", {31'd0, wb_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwb.wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rstwb.nzcv", {28'd0, cpsr_nzcv}, 32'd0);
    check("rstwb.wb_data", wb_data, 32'd0);
    #3 rst_n = 1'b1; wb_ready = 1'b1;
    tick(); tick();
    check("rstwb.after", {30'd0, wb_valid, req_ready}, 32'd1);
    model_nzcv = 4'b0000;

    // Randomized ops against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) set_flags(4'($urandom));
      model_op($sformatf("rnd%0d", i), 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
               $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom,
               $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
